// File: rtl/pc_pkg.sv
// Shared types for the program counter: the per-cycle operation code and the
// strobe priority decoder.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_CALL,
        OP_RET,
        OP_CLR
    } pc_op_t;

    // Exactly one action per cycle: clr > ret > call > lp > cp.
    function automatic pc_op_t pc_decode(
        input logic clr,
        input logic ret,
        input logic call,
        input logic lp,
        input logic cp
    );
        if (clr)       return OP_CLR;
        else if (ret)  return OP_RET;
        else if (call) return OP_CALL;
        else if (lp)   return OP_LOAD;
        else if (cp)   return OP_INC;
        else           return OP_HOLD;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. The caller guarantees push only when not full and pop
// only when not empty; dout always shows the top entry.
module ret_stack #(
    parameter int WIDTH       = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W  = $clog2(STACK_DEPTH + 1);
    localparam int ADDR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0]  mem [STACK_DEPTH];
    logic [PTR_W-1:0]  sp;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;

    assign wr_idx = ADDR_W'(sp);
    assign rd_idx = ADDR_W'(sp - PTR_W'(1));
    assign dout   = mem[rd_idx];
    assign full   = (sp == PTR_W'(STACK_DEPTH));
    assign empty  = (sp == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + PTR_W'(1);
        end else if (pop) begin
            sp <= sp - PTR_W'(1);
        end
    end

    // NOTE: entries are deliberately not reset; an empty stack never exposes
    // them, and leaving them reset-free lets the array map onto plain storage.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with single-cycle load, call/ret through a return-address
// stack, wrap pulse, sticky stack error and a registered bus output enable.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ret,
    input  logic             call,
    input  logic             lp,
    input  logic             cp,
    input  logic             ep,
    input  logic [WIDTH-1:0] bits_in,
    output logic [WIDTH-1:0] bits_out,
    output logic             bits_oe,
    output logic [WIDTH-1:0] pc,
    output logic             wrap,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);

    pc_op_t           op;
    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] stk_top;
    logic [WIDTH-1:0] pc_next;
    logic             wrap_next;
    logic             err_next;

    assign op     = pc_decode(clr, ret, call, lp, cp);
    assign clear  = rst || (op == OP_CLR);
    assign pc_inc = pc + WIDTH'(1);
    assign push   = !rst && (op == OP_CALL) && !stk_full;
    assign pop    = !rst && (op == OP_RET) && !stk_empty;

    ret_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (clear),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        pc_next   = pc;
        wrap_next = 1'b0;
        err_next  = stk_err;
        unique case (op)
            OP_INC: begin
                pc_next   = pc_inc;
                wrap_next = (pc == '1);
            end
            OP_LOAD: pc_next = bits_in;
            OP_CALL: begin
                if (stk_full) err_next = 1'b1;
                else          pc_next  = bits_in;
            end
            OP_RET: begin
                if (stk_empty) err_next = 1'b1;
                else           pc_next  = stk_top;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            pc      <= RESET_ADDR;
            wrap    <= 1'b0;
            stk_err <= 1'b0;
            bits_oe <= 1'b0;
        end else begin
            pc      <= pc_next;
            wrap    <= wrap_next;
            stk_err <= err_next;
            bits_oe <= ep;
        end
    end

    // Plain mux rather than Z: the shared-bus tri-state lives at the top level.
    assign bits_out = bits_oe ? pc : '0;

endmodule
